// File: rtl/regfile_pkg.sv
// Shared widths, command op codes and controller state encodings for the
// register-file access controller.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int IDX_W_DEF  = 2;

   typedef enum logic [1:0] {
      OP_CLEAR = 2'b00,
      OP_READ1 = 2'b01,
      OP_READ2 = 2'b10,
      OP_WRITE = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_FINISH = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/rf_strobe_timer.sv
// Loadable down-counter that times the SETUP and STROBE phases; phase_done
// is high once the loaded count has run out.
module rf_strobe_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_phase_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_phase_done = (r_cnt == '0);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences one-shot commands into setup/strobe/hold accesses on a 4x16
// register file and returns read operands over a valid/ready response.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_ra,
   input  logic [IDX_W-1:0]  cmd_rb,
   input  logic [IDX_W-1:0]  cmd_rd,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_a,
   output logic [DATA_W-1:0] rsp_b,
   output logic [IDX_W-1:0]  rf_index,
   output logic [DATA_W-1:0] rf_data_in,
   input  logic [DATA_W-1:0] rf_data_out,
   output logic              rf_rEn,
   output logic              rf_wEn,
   output logic              rf_clear
);

   localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);

   state_e            r_state, w_state_nxt;
   op_e               r_op;
   logic [IDX_W-1:0]  r_rb;
   logic              r_second;
   logic              w_accept, w_read_op, w_again;
   logic              w_phase_done, w_tmr_load;
   logic [CNT_W-1:0]  w_tmr_val;
   logic              w_cmd_ready_nxt, w_rsp_valid_nxt;
   logic              w_ren_nxt, w_wen_nxt, w_clr_nxt;
   logic [IDX_W-1:0]  w_index_nxt;
   logic [DATA_W-1:0] w_din_nxt, w_a_nxt, w_b_nxt;

   assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
   assign w_read_op = (r_op == OP_READ1) || (r_op == OP_READ2);
   assign w_again   = (r_op == OP_READ2) && !r_second;

   rf_strobe_timer #(.CNT_W(CNT_W)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_tmr_load),
      .i_load_val   (w_tmr_val),
      .o_phase_done (w_phase_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (cmd_valid) w_state_nxt = ST_SETUP;
         ST_SETUP:  if (w_phase_done) w_state_nxt = ST_STROBE;
         ST_STROBE: if (w_phase_done) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = w_again ? ST_SETUP : ST_RESP;
         ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs; strobes follow the state being entered.
   always_comb begin
      w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
      w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
      w_ren_nxt       = (w_state_nxt == ST_STROBE) && w_read_op;
      w_wen_nxt       = (w_state_nxt == ST_STROBE) && (r_op == OP_WRITE);
      w_clr_nxt       = (w_state_nxt == ST_STROBE) && (r_op == OP_CLEAR);
      w_index_nxt     = rf_index;
      w_din_nxt       = rf_data_in;
      w_a_nxt         = rsp_a;
      w_b_nxt         = rsp_b;
      w_tmr_load      = 1'b0;
      w_tmr_val       = SETUP_LD;
      if (w_accept) begin
         w_a_nxt    = '0;
         w_b_nxt    = '0;
         w_tmr_load = 1'b1;
         case (op_e'(cmd_op))
            OP_WRITE: begin
               w_index_nxt = cmd_rd;
               w_din_nxt   = cmd_wdata;
            end
            OP_READ1, OP_READ2: w_index_nxt = cmd_ra;
            default: ;
         endcase
      end
      if (r_state == ST_SETUP && w_phase_done) begin
         w_tmr_load = 1'b1;
         w_tmr_val  = STROBE_LD;
      end
      if (r_state == ST_FINISH) begin
         if (w_read_op && r_second) w_b_nxt = rf_data_out;
         if (w_read_op && !r_second) w_a_nxt = rf_data_out;
         if (w_again) begin
            w_index_nxt = r_rb;
            w_tmr_load  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= OP_CLEAR;
         r_rb     <= '0;
         r_second <= 1'b0;
      end else if (w_accept) begin
         r_op     <= op_e'(cmd_op);
         r_rb     <= cmd_rb;
         r_second <= 1'b0;
      end else if (r_state == ST_FINISH && w_again) begin
         r_second <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rf_rEn     <= 1'b0;
         rf_wEn     <= 1'b0;
         rf_clear   <= 1'b0;
         rf_index   <= '0;
         rf_data_in <= '0;
         rsp_a      <= '0;
         rsp_b      <= '0;
      end else begin
         cmd_ready  <= w_cmd_ready_nxt;
         rsp_valid  <= w_rsp_valid_nxt;
         rf_rEn     <= w_ren_nxt;
         rf_wEn     <= w_wen_nxt;
         rf_clear   <= w_clr_nxt;
         rf_index   <= w_index_nxt;
         rf_data_in <= w_din_nxt;
         rsp_a      <= w_a_nxt;
         rsp_b      <= w_b_nxt;
      end
   end

endmodule
